// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and default Galois tap masks for the LFSR random source
package lfsr_pkg;

    typedef enum logic [0:0] {WARM, RUN} lfsr_state_e;

    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Galois LFSR state register with load and single-step advance
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               OUT_W = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_W16,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] state_o,
    output logic [OUT_W-1:0] cand_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    // Shift right; the bit falling off the bottom decides whether the taps fold back in.
    assign state_d = {1'b0, state_q[WIDTH-1:1]} ^ (state_q[0] ? TAPS : '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SEED;
        end else if (load_i) begin
            state_q <= load_val_i;
        end else if (advance_i) begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign cand_o  = state_d[OUT_W-1:0];

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - seeded LFSR random source with warm-up, rejection sampling and valid/ready output
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = TAPS_W16,
    parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
    parameter int               OUT_W  = 4,
    parameter int               WARMUP = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_seed_we,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [OUT_W-1:0] i_range,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_random_out,
    output logic             o_busy
);

    localparam int          CNT_W       = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);
    localparam lfsr_state_e START_STATE = (WARMUP == 0) ? RUN : WARM;
    localparam logic [CNT_W-1:0] LAST_WARM = CNT_W'(WARMUP - 1);

    lfsr_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] out_q, out_d;

    logic             lfsr_load;
    logic             lfsr_advance;
    logic [WIDTH-1:0] lfsr_load_val;
    logic [WIDTH-1:0] lfsr_state;
    logic [OUT_W-1:0] cand;

    lfsr_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (lfsr_load),
        .advance_i  (lfsr_advance),
        .load_val_i (lfsr_load_val),
        .state_o    (lfsr_state),
        .cand_o     (cand)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        valid_d       = valid_q;
        out_d         = out_q;
        lfsr_load     = 1'b0;
        lfsr_advance  = 1'b0;
        lfsr_load_val = i_seed;
        if (i_seed_we) begin
            // A zero seed would lock the LFSR, so fall back to the reset seed.
            lfsr_load     = 1'b1;
            lfsr_load_val = (i_seed == '0) ? SEED : i_seed;
            valid_d       = 1'b0;
            cnt_d         = '0;
            state_d       = START_STATE;
        end else begin
            case (state_q)
                WARM: begin
                    lfsr_advance = 1'b1;
                    if (cnt_q == LAST_WARM) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!valid_q || i_ready) begin
                        lfsr_advance = 1'b1;
                        if (i_range == '0 || cand < i_range) begin
                            valid_d = 1'b1;
                            out_d   = cand;
                        end else begin
                            valid_d = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= START_STATE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    // The all-zero state is a fixed point; seeding rules must keep us out of it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (lfsr_state != '0);
        end
    end

    assign o_valid      = valid_q;
    assign o_random_out = out_q;
    assign o_busy       = (state_q == WARM);

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng against a period-table reference model
module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       rst;
    logic       seed_we;
    logic [3:0] seed;
    logic [3:0] range_v;
    logic       ready;

    logic       v0, b0, v3, b3;
    logic [3:0] o0, o3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4), .WARMUP(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_seed_we(seed_we), .i_seed(seed), .i_range(range_v),
        .i_ready(ready), .o_valid(v0), .o_random_out(o0), .o_busy(b0)
    );

    lfsr_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .OUT_W(4), .WARMUP(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_seed_we(seed_we), .i_seed(seed), .i_range(range_v),
        .i_ready(ready), .o_valid(v3), .o_random_out(o3), .o_busy(b3)
    );

    // Full period of the 4-bit sequence starting after seed 1; index 14 is the seed itself.
    logic [3:0] tbl [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                             4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    int         wu [2]   = '{0, 3};
    int         m_pos [2];
    int         m_cnt [2];
    bit         m_valid [2];
    bit         m_run [2];
    logic [3:0] m_out [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [3:0] s);
        for (int i = 0; i < 15; i++) if (tbl[i] == s) return i;
        return 14;
    endfunction

    task automatic model_step();
        logic [3:0] c;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pos[k] = 14; m_valid[k] = 0; m_out[k] = 0; m_cnt[k] = 0; m_run[k] = (wu[k] == 0);
            end else if (seed_we) begin
                m_pos[k] = idx_of(seed == 0 ? 4'h1 : seed);
                m_valid[k] = 0; m_cnt[k] = 0; m_run[k] = (wu[k] == 0);
            end else if (!m_run[k]) begin
                m_pos[k] = (m_pos[k] + 1) % 15;
                m_cnt[k]++;
                if (m_cnt[k] == wu[k]) begin
                    m_run[k] = 1; m_cnt[k] = 0;
                end
            end else if (!m_valid[k] || ready) begin
                m_pos[k] = (m_pos[k] + 1) % 15;
                c = tbl[m_pos[k]];
                if (range_v == 0 || c < range_v) begin
                    m_valid[k] = 1; m_out[k] = c;
                end else begin
                    m_valid[k] = 0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("valid0", 32'(v0), 32'(m_valid[0]));
        check("out0",   32'(o0), 32'(m_out[0]));
        check("busy0",  32'(b0), 32'(!m_run[0]));
        check("valid3", 32'(v3), 32'(m_valid[1]));
        check("out3",   32'(o3), 32'(m_out[1]));
        check("busy3",  32'(b3), 32'(!m_run[1]));
    endtask

    initial begin
        rst = 1; seed_we = 0; seed = 0; range_v = 0; ready = 1;
        @(negedge clk);
        cycle();
        check("rst_valid0", 32'(v0), 0);
        check("rst_out0",   32'(o0), 0);
        check("rst_busy3",  32'(b3), 1);
        check("rst_busy0",  32'(b0), 0);
        rst = 0;

        // Full period, plus warm-up behaviour of the WARMUP=3 instance.
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (i == 1)  check("first_out", 32'(o0), 32'hC);
            if (i == 3)  check("warm_busy_end", 32'(b3), 0);
            if (i == 4)  check("warm_first", 32'({v3, o3}), 32'h1D);
            if (i == 15) check("period_end", 32'(o0), 32'h1);
            if (i == 16) check("period_wrap", 32'({v0, o0}), 32'h1C);
        end

        // Backpressure on value 3.
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < 3; i++) cycle();
        check("bp_start", 32'({v0, o0}), 32'h13);
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_hold", 32'({v0, o0}), 32'h13);
        end
        ready = 1;
        cycle();
        check("bp_next", 32'(o0), 32'hD);

        // Zero seed write while a value is held.
        ready = 0; seed_we = 1; seed = 0;
        cycle();
        check("seed_drop", 32'(v0), 0);
        seed_we = 0; ready = 1;
        cycle();
        check("seed_restart", 32'({v0, o0}), 32'h1C);

        // Range limit over two periods.
        range_v = 4'd5;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (v0) check("range_ok", 32'(o0 < 4'd5), 1);
        end
        range_v = 0;

        // Reset wins over a simultaneous seed write.
        rst = 1; seed_we = 1; seed = 4'h9;
        cycle();
        check("rst_prio", 32'(v0), 0);
        rst = 0; seed_we = 0;
        cycle();
        check("rst_restart", 32'({v0, o0}), 32'h1C);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            ready   = ($urandom_range(0, 3) != 0);
            range_v = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            seed_we = ($urandom_range(0, 24) == 0);
            seed    = 4'($urandom_range(0, 15));
            rst     = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
